// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the fetch/branch sequencer: widths, control-flow op codes and FSM states.
package pc_sequencer_pkg;

  localparam int PC_W = 19;

  localparam logic [2:0] OP_SEQ  = 3'b000;
  localparam logic [2:0] OP_BRQ  = 3'b001;
  localparam logic [2:0] OP_BRNE = 3'b010;
  localparam logic [2:0] OP_JMP  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_ACK,
    S_RESOLVE,
    S_HALTED
  } state_e;

endpackage

// File: rtl/pc_sequencer_ras.sv
// Return-address stack: small LIFO; pushes when full and pops when empty are dropped.
module return_addr_stack #(
  parameter int W     = 19,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] top_data,
  output logic         full,
  output logic         empty
);
  import pc_sequencer_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic [AW:0]  count_q, count_d;
  logic [AW:0]  top_idx;

  assign full     = (count_q == (AW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign top_idx  = count_q - 1'b1;
  assign top_data = mem_q[top_idx[AW-1:0]];

  always_comb begin
    mem_d   = mem_q;
    count_d = count_q;
    if (push && !full) begin
      mem_d[count_q[AW-1:0]] = push_data;
      count_d                = count_q + 1'b1;
    end else if (pop && !empty) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/branch controller: owns the PC, runs the imem req/ack handshake and resolves control flow.
module pc_sequencer #(
  parameter int              PC_W      = 19,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            halt_req,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  output logic            br_ready,
  input  logic            br_valid,
  input  logic [2:0]      br_op,
  input  logic [PC_W-1:0] r2,
  input  logic [PC_W-1:0] r3,
  input  logic [PC_W-1:0] branch_addr,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            ras_ovf,
  output logic            ras_unf
);
  import pc_sequencer_pkg::*;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            ack_seen_q, ack_seen_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;
  logic            accept;
  logic [PC_W-1:0] seq_pc;
  logic            ras_push, ras_pop, ras_full, ras_empty;
  logic [PC_W-1:0] ras_top;

  assign accept    = (state_q == S_RESOLVE) && br_valid;
  assign seq_pc    = pc_q + 1'b1;
  assign pc        = pc_q;
  assign imem_addr = pc_q;
  assign ras_ovf   = ovf_q;
  assign ras_unf   = unf_q;

  return_addr_stack #(.W(PC_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (seq_pc),
    .top_data  (ras_top),
    .full      (ras_full),
    .empty     (ras_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      ack_seen_q <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ack_seen_q <= ack_seen_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  // An ack that lands during FETCH is remembered so WAIT_ACK can pass straight through.
  always_comb begin
    state_d    = state_q;
    ack_seen_d = (state_q == S_FETCH) && imem_ack;
    case (state_q)
      S_IDLE, S_HALTED: if (start) state_d = S_FETCH;
      S_FETCH:          state_d = S_WAIT_ACK;
      S_WAIT_ACK:       if (imem_ack || ack_seen_q) state_d = S_RESOLVE;
      S_RESOLVE:        if (br_valid) state_d = halt_req ? S_HALTED : S_FETCH;
      default:          state_d = S_IDLE;
    endcase
  end

  always_comb begin
    imem_req = (state_q == S_FETCH) || ((state_q == S_WAIT_ACK) && !ack_seen_q);
    br_ready = (state_q == S_RESOLVE);
    busy     = (state_q == S_FETCH) || (state_q == S_WAIT_ACK) || (state_q == S_RESOLVE);
  end

  always_comb begin
    pc_d     = pc_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (accept) begin
      case (br_op)
        OP_BRQ:  pc_d = (r2 == r3) ? branch_addr : seq_pc;
        OP_BRNE: pc_d = (r2 != r3) ? branch_addr : seq_pc;
        OP_JMP:  pc_d = branch_addr;
        OP_CALL: begin
          ras_push = 1'b1;
          if (ras_full) ovf_d = 1'b1;
          pc_d = branch_addr;
        end
        OP_RET: begin
          ras_pop = 1'b1;
          if (ras_empty) begin
            unf_d = 1'b1;
            pc_d  = seq_pc;
          end else begin
            pc_d = ras_top;
          end
        end
        default: pc_d = seq_pc;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random control flow vs a queue-based model.
module tb_pc_sequencer;

  localparam int PC_W = 19;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            start;
  logic            halt_req;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic            br_ready;
  logic            br_valid;
  logic [2:0]      br_op;
  logic [PC_W-1:0] r2, r3, branch_addr;
  logic [PC_W-1:0] pc;
  logic            busy, ras_ovf, ras_unf;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [PC_W-1:0] mPc;
  logic [PC_W-1:0] mRas[$];
  logic            mOvf, mUnf;

  pc_sequencer #(.PC_W(PC_W), .RESET_PC('0), .RAS_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .halt_req    (halt_req),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .br_ready    (br_ready),
    .br_valid    (br_valid),
    .br_op       (br_op),
    .r2          (r2),
    .r3          (r3),
    .branch_addr (branch_addr),
    .pc          (pc),
    .busy        (busy),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void modelReset();
    mPc = '0;
    mRas.delete();
    mOvf = 1'b0;
    mUnf = 1'b0;
  endfunction

  // Next-pc rules written directly from the instruction semantics; the stack is a plain queue.
  function automatic void modelResolve(input logic [2:0] op, input logic [PC_W-1:0] a,
                                       input logic [PC_W-1:0] b, input logic [PC_W-1:0] tgt);
    logic [PC_W-1:0] seq;
    seq = mPc + 1'b1;
    case (op)
      3'd1: mPc = (a == b) ? tgt : seq;
      3'd2: mPc = (a != b) ? tgt : seq;
      3'd3: mPc = tgt;
      3'd4: begin
        if (mRas.size() < DEPTH) mRas.push_back(seq);
        else mOvf = 1'b1;
        mPc = tgt;
      end
      3'd5: begin
        if (mRas.size() > 0) mPc = mRas.pop_back();
        else begin
          mPc  = seq;
          mUnf = 1'b1;
        end
      end
      default: mPc = seq;
    endcase
  endfunction

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitReq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic waitReady(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (br_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full instruction: fetch with ack after ackDelay extra cycles, then resolve.
  task automatic applyStimulus(input logic [2:0] op, input logic [PC_W-1:0] a,
                               input logic [PC_W-1:0] b, input logic [PC_W-1:0] tgt,
                               input bit halt, input int ackDelay);
    bit ok;
    waitReq(ok);
    if (!ok) begin
      checkOutput("req_timeout", 32'(imem_req), 32'd1);
      return;
    end
    checkOutput("fetch_addr", 32'(imem_addr), 32'(mPc));
    checkOutput("busy_fetch", 32'(busy), 32'd1);
    for (int d = 0; d < ackDelay; d++) begin
      @(negedge clk);
      checkOutput("req_held", 32'(imem_req), 32'd1);
      checkOutput("addr_held", 32'(imem_addr), 32'(mPc));
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    waitReady(ok);
    if (!ok) begin
      checkOutput("ready_timeout", 32'(br_ready), 32'd1);
      return;
    end
    br_valid    = 1'b1;
    br_op       = op;
    r2          = a;
    r3          = b;
    branch_addr = tgt;
    halt_req    = halt;
    @(negedge clk);
    br_valid = 1'b0;
    halt_req = 1'b0;
    modelResolve(op, a, b, tgt);
    checkOutput("pc", 32'(pc), 32'(mPc));
    checkOutput("ras_ovf", 32'(ras_ovf), 32'(mOvf));
    checkOutput("ras_unf", 32'(ras_unf), 32'(mUnf));
    checkOutput("ready_drop", 32'(br_ready), 32'd0);
    if (halt) begin
      checkOutput("busy_halted", 32'(busy), 32'd0);
      @(negedge clk);
      checkOutput("halted_no_req", 32'(imem_req), 32'd0);
      pulseStart();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit ok;
    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_ack = 1'b0;
    br_valid = 1'b0; br_op = '0; r2 = '0; r3 = '0; branch_addr = '0;
    modelReset();
    #12;
    checkOutput("rst_pc", 32'(pc), 32'd0);
    checkOutput("rst_req", 32'(imem_req), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_ready", 32'(br_ready), 32'd0);
    checkOutput("rst_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_no_start", 32'(busy), 32'd0);
    pulseStart();

    for (int i = 0; i < 3; i++) applyStimulus(3'd0, '0, '0, '0, 1'b0, 0);

    applyStimulus(3'd3, '0, '0, 19'd200, 1'b0, 1);
    applyStimulus(3'd1, 19'd2, 19'd2, 19'd150, 1'b0, 0);
    applyStimulus(3'd3, '0, '0, 19'd200, 1'b0, 0);
    applyStimulus(3'd1, 19'd2, 19'd3, 19'd150, 1'b0, 2);
    applyStimulus(3'd3, '0, '0, 19'd200, 1'b0, 0);
    applyStimulus(3'd2, 19'd2, 19'd3, 19'd150, 1'b0, 0);

    applyStimulus(3'd3, '0, '0, 19'd10, 1'b0, 0);
    applyStimulus(3'd4, '0, '0, 19'd500, 1'b0, 0);
    applyStimulus(3'd5, '0, '0, '0, 1'b0, 0);
    applyStimulus(3'd5, '0, '0, '0, 1'b0, 0);

    for (int i = 1; i <= 5; i++) applyStimulus(3'd4, '0, '0, 19'(i * 1000), 1'b0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(3'd5, '0, '0, '0, 1'b0, 1);

    applyStimulus(3'd3, '0, '0, 19'h7FFFF, 1'b0, 0);
    applyStimulus(3'd0, '0, '0, '0, 1'b0, 5);

    applyStimulus(3'd3, '0, '0, 19'd321, 1'b1, 0);
    applyStimulus(3'd0, '0, '0, '0, 1'b0, 0);

    waitReq(ok);
    @(negedge clk);
    checkOutput("wait_ack_req", 32'(imem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rst_req", 32'(imem_req), 32'd0);
    checkOutput("async_rst_pc", 32'(pc), 32'd0);
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    modelReset();
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_idle", 32'(busy), 32'd0);
    checkOutput("post_rst_flags", {30'd0, ras_ovf, ras_unf}, 32'd0);
    pulseStart();

    for (int i = 0; i < 80; i++) begin
      logic [PC_W-1:0] a, b, tgt;
      a   = PC_W'($urandom);
      b   = ($urandom_range(0, 1) == 0) ? a : PC_W'($urandom);
      tgt = PC_W'($urandom);
      applyStimulus(3'($urandom_range(0, 7)), a, b, tgt,
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
